// File: rtl/execute_stage_pkg.sv
// Shared E-stage definitions: opcode/sub-opcode classes, exception causes,
// width typedefs, the E latch layout and the divider state encoding.
package execute_stage_pkg;

    typedef logic        i1;
    typedef logic [4:0]  i5;
    typedef logic [5:0]  i6;
    typedef logic [31:0] i32;
    typedef logic [63:0] i64;

    // icode: primary opcode class
    localparam i6 IC_SPECIAL  = 6'h00;
    localparam i6 IC_REGIMM   = 6'h01;
    localparam i6 IC_JAL      = 6'h03;
    localparam i6 IC_ADDI     = 6'h08;
    localparam i6 IC_ADDIU    = 6'h09;
    localparam i6 IC_SLTI     = 6'h0A;
    localparam i6 IC_SLTIU    = 6'h0B;
    localparam i6 IC_ANDI     = 6'h0C;
    localparam i6 IC_ORI      = 6'h0D;
    localparam i6 IC_XORI     = 6'h0E;
    localparam i6 IC_LUI      = 6'h0F;
    localparam i6 IC_SPECIAL2 = 6'h1C;
    localparam i6 IC_LB       = 6'h20;
    localparam i6 IC_LH       = 6'h21;
    localparam i6 IC_LW       = 6'h23;
    localparam i6 IC_LBU      = 6'h24;
    localparam i6 IC_LHU      = 6'h25;
    localparam i6 IC_SB       = 6'h28;
    localparam i6 IC_SH       = 6'h29;
    localparam i6 IC_SW       = 6'h2B;

    // acode: function field for SPECIAL / SPECIAL2, rt field for REGIMM
    localparam i6 AC_SLL    = 6'h00;
    localparam i6 AC_SRL    = 6'h02;
    localparam i6 AC_SRA    = 6'h03;
    localparam i6 AC_SLLV   = 6'h04;
    localparam i6 AC_SRLV   = 6'h06;
    localparam i6 AC_SRAV   = 6'h07;
    localparam i6 AC_JALR   = 6'h09;
    localparam i6 AC_MFHI   = 6'h10;
    localparam i6 AC_MTHI   = 6'h11;
    localparam i6 AC_MFLO   = 6'h12;
    localparam i6 AC_MTLO   = 6'h13;
    localparam i6 AC_MULT   = 6'h18;
    localparam i6 AC_MULTU  = 6'h19;
    localparam i6 AC_DIV    = 6'h1A;
    localparam i6 AC_DIVU   = 6'h1B;
    localparam i6 AC_ADD    = 6'h20;
    localparam i6 AC_ADDU   = 6'h21;
    localparam i6 AC_SUB    = 6'h22;
    localparam i6 AC_SUBU   = 6'h23;
    localparam i6 AC_AND    = 6'h24;
    localparam i6 AC_OR     = 6'h25;
    localparam i6 AC_XOR    = 6'h26;
    localparam i6 AC_NOR    = 6'h27;
    localparam i6 AC_SLT    = 6'h2A;
    localparam i6 AC_SLTU   = 6'h2B;
    localparam i6 AC_MUL    = 6'h02;
    localparam i6 AC_BLTZAL = 6'h10;
    localparam i6 AC_BGEZAL = 6'h11;

    // bit5 = valid, bits 4:0 = cause
    localparam i6 EXC_OV = 6'b101100;
    localparam i6 EXC_RI = 6'b101010;

    typedef struct packed {
        i32 pc;
        i32 val1;
        i32 val2;
        i32 valt;
        i6  icode;
        i6  acode;
        i6  exc;
        i5  dst;
        i1  ids;
    } e_latch_t;

    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

    function automatic i1 is_load_op(input i6 icode);
        return icode inside {IC_LB, IC_LH, IC_LW, IC_LBU, IC_LHU};
    endfunction

endpackage

// File: rtl/execute_stage_div_iter.sv
// Iterative 32-step restoring divider, signed or unsigned, HI/LO-style results.
// Latency: 1 load cycle + 32 step cycles, then holds results in DONE until ack.
// Backpressure: busy while loading/running; DONE waits for ack; abort returns to IDLE.
module div_iter
    import execute_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        sgn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        abort,
    input  logic        ack,
    output logic        busy,
    output logic        done,
    output logic [31:0] q,
    output logic [31:0] r
);

    div_state_t  state, state_nxt;
    logic        load, step;
    logic [4:0]  cnt;
    logic [31:0] quo, rem, dvs;
    logic        neg_q, neg_r;
    logic [32:0] rem_sh;
    logic [32:0] rem_sub;
    logic        step_ge;

    always_ff @(posedge clk) begin
        if (!resetn) state <= DIV_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            DIV_IDLE: if (start) begin
                busy      = 1'b1;
                load      = 1'b1;
                state_nxt = DIV_RUN;
            end
            DIV_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == 5'd31) state_nxt = DIV_DONE;
            end
            DIV_DONE: begin
                done = 1'b1;
                if (ack) state_nxt = DIV_IDLE;
            end
            default: state_nxt = DIV_IDLE;
        endcase
        if (abort) begin
            state_nxt = DIV_IDLE;
            load      = 1'b0;
            step      = 1'b0;
        end
    end

    // One restoring step: shift next dividend bit into the partial remainder.
    always_comb begin
        rem_sh  = {rem, quo[31]};
        rem_sub = rem_sh - {1'b0, dvs};
        step_ge = (rem_sh >= {1'b0, dvs});
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (load) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= (sgn && a[31]) ? (~a + 32'd1) : a;
            dvs   <= (sgn && b[31]) ? (~b + 32'd1) : b;
            neg_q <= sgn && (a[31] ^ b[31]);
            neg_r <= sgn && a[31];
        end else if (step) begin
            cnt <= cnt + 5'd1;
            quo <= {quo[30:0], step_ge};
            rem <= step_ge ? rem_sub[31:0] : rem_sh[31:0];
        end
    end

    assign q = neg_q ? (~quo + 32'd1) : quo;
    assign r = neg_r ? (~rem + 32'd1) : rem;

endmodule

// File: rtl/execute_stage.sv
// MIPS execute stage: ALU/shift/compare/multiply/address, HI/LO, E forwarding.
// Latency: results combinational from the E latch; DIV occupies E for 34 cycles.
// Backpressure: E_stall holds the latch; e_busy asks control to stall E and upstream.
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        E_stall,
    input  logic        E_bubble,
    input  logic        flush,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_val1,
    input  logic [31:0] d_val2,
    input  logic [31:0] d_valt,
    input  logic [5:0]  d_icode,
    input  logic [5:0]  d_acode,
    input  logic [5:0]  d_excCode,
    input  logic [4:0]  d_dst,
    input  logic        d_inDelaySlot,
    output logic [31:0] e_pc,
    output logic [31:0] e_val3,
    output logic [31:0] e_valt,
    output logic [5:0]  e_icode,
    output logic [5:0]  e_acode,
    output logic [5:0]  e_excCode,
    output logic [4:0]  e_dst,
    output logic        e_inDelaySlot,
    output logic        e_isLoad,
    output logic        e_busy
);

    e_latch_t lat, cap;
    i32       a, b, hi, lo, sum, diff, sll_v, srl_v, sra_v, result;
    i64       prod;
    logic     ovf_add, ovf_sub, ovf, special;
    logic     is_div, advance, hilo_ok;
    logic     div_busy, div_done;
    i32       div_q, div_r;

    // A faulting instruction keeps only what the exception path needs.
    always_comb begin
        cap     = '0;
        cap.pc  = d_pc;
        cap.exc = d_excCode;
        cap.ids = d_inDelaySlot;
        if (!d_excCode[5]) begin
            cap.val1  = d_val1;
            cap.val2  = d_val2;
            cap.valt  = d_valt;
            cap.icode = d_icode;
            cap.acode = d_acode;
            cap.dst   = d_dst;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) lat <= '0;
        else if (E_stall)     lat <= lat;
        else if (E_bubble)    lat <= '0;
        else                  lat <= cap;
    end

    assign a       = lat.val1;
    assign b       = lat.val2;
    assign special = (lat.icode == IC_SPECIAL);

    always_comb begin
        sum     = a + b;
        diff    = a - b;
        sll_v   = b << a[4:0];
        srl_v   = b >> a[4:0];
        sra_v   = $signed(b) >>> a[4:0];
        ovf_add = (a[31] == b[31]) && (sum[31] != a[31]);
        ovf_sub = (a[31] != b[31]) && (diff[31] != a[31]);
        // MULTU zero-extends; everything else sign-extends (MUL low half is identical).
        if (special && lat.acode == AC_MULTU) prod = {32'b0, a} * {32'b0, b};
        else prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    end

    always_comb begin
        result = '0;
        case (lat.icode)
            IC_SPECIAL: begin
                case (lat.acode)
                    AC_SLL, AC_SLLV:  result = sll_v;
                    AC_SRL, AC_SRLV:  result = srl_v;
                    AC_SRA, AC_SRAV:  result = sra_v;
                    AC_JALR:          result = b;
                    AC_MFHI:          result = hi;
                    AC_MFLO:          result = lo;
                    AC_ADD, AC_ADDU:  result = sum;
                    AC_SUB, AC_SUBU:  result = diff;
                    AC_AND:           result = a & b;
                    AC_OR:            result = a | b;
                    AC_XOR:           result = a ^ b;
                    AC_NOR:           result = ~(a | b);
                    AC_SLT:           result = {31'b0, $signed(a) < $signed(b)};
                    AC_SLTU:          result = {31'b0, a < b};
                    default:          result = '0;
                endcase
            end
            IC_REGIMM:  if (lat.acode == AC_BLTZAL || lat.acode == AC_BGEZAL) result = b;
            IC_JAL, IC_LUI: result = b;
            IC_ADDI, IC_ADDIU, IC_LB, IC_LH, IC_LW, IC_LBU, IC_LHU,
            IC_SB, IC_SH, IC_SW: result = sum;
            IC_SLTI:    result = {31'b0, $signed(a) < $signed(b)};
            IC_SLTIU:   result = {31'b0, a < b};
            IC_ANDI:    result = a & b;
            IC_ORI:     result = a | b;
            IC_XORI:    result = a ^ b;
            IC_SPECIAL2: if (lat.acode == AC_MUL) result = prod[31:0];
            default:    result = '0;
        endcase
    end

    assign ovf = !lat.exc[5] &&
                 (((special && lat.acode == AC_ADD) || lat.icode == IC_ADDI) ? ovf_add :
                  (special && lat.acode == AC_SUB) ? ovf_sub : 1'b0);

    assign is_div = special && (lat.acode == AC_DIV || lat.acode == AC_DIVU);

    div_iter u_div (
        .clk    (clk),
        .resetn (resetn),
        .start  (is_div),
        .sgn    (lat.acode == AC_DIV),
        .a      (a),
        .b      (b),
        .abort  (flush),
        .ack    (advance),
        .busy   (div_busy),
        .done   (div_done),
        .q      (div_q),
        .r      (div_r)
    );

    assign advance = !E_stall && !div_busy;
    assign hilo_ok = advance && !flush && !e_excCode[5];

    // HI/LO commit only as the owning instruction leaves E.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (hilo_ok && special) begin
            case (lat.acode)
                AC_MULT, AC_MULTU: {hi, lo} <= prod;
                AC_MTHI:           hi <= a;
                AC_MTLO:           lo <= a;
                AC_DIV, AC_DIVU:   if (div_done) {hi, lo} <= {div_r, div_q};
                default: ;
            endcase
        end
    end

    assign e_pc          = lat.pc;
    assign e_val3        = result;
    assign e_valt        = lat.valt;
    assign e_icode       = lat.icode;
    assign e_acode       = lat.acode;
    assign e_excCode     = lat.exc[5] ? lat.exc : (ovf ? EXC_OV : 6'd0);
    assign e_dst         = ovf ? 5'd0 : lat.dst;
    assign e_inDelaySlot = lat.ids;
    assign e_isLoad      = is_load_op(lat.icode);
    assign e_busy        = div_busy;

endmodule

// File: tb/tb_execute_stage.sv
// Randomized self-checking bench for execute_stage against an arithmetic reference model.
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic        clk = 1'b0;
    logic        resetn, E_stall, E_bubble, flush;
    logic [31:0] d_pc, d_val1, d_val2, d_valt;
    logic [5:0]  d_icode, d_acode, d_excCode;
    logic [4:0]  d_dst;
    logic        d_inDelaySlot;
    logic [31:0] e_pc, e_val3, e_valt;
    logic [5:0]  e_icode, e_acode, e_excCode;
    logic [4:0]  e_dst;
    logic        e_inDelaySlot, e_isLoad, e_busy;

    execute_stage dut (
        .clk(clk), .resetn(resetn), .E_stall(E_stall), .E_bubble(E_bubble), .flush(flush),
        .d_pc(d_pc), .d_val1(d_val1), .d_val2(d_val2), .d_valt(d_valt),
        .d_icode(d_icode), .d_acode(d_acode), .d_excCode(d_excCode), .d_dst(d_dst),
        .d_inDelaySlot(d_inDelaySlot),
        .e_pc(e_pc), .e_val3(e_val3), .e_valt(e_valt), .e_icode(e_icode), .e_acode(e_acode),
        .e_excCode(e_excCode), .e_dst(e_dst), .e_inDelaySlot(e_inDelaySlot),
        .e_isLoad(e_isLoad), .e_busy(e_busy)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m_hi, m_lo;
    logic [31:0] cur_pc, cur_valt;
    logic        cur_ids;
    logic [11:0] op_tab [0:39];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h0;
            4: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [5:0] ic, ac, input logic [31:0] a, b);
        int     sa = a;
        int     sb = b;
        longint r;
        if ((ic == IC_SPECIAL && ac == AC_ADD) || ic == IC_ADDI) r = longint'(sa) + longint'(sb);
        else if (ic == IC_SPECIAL && ac == AC_SUB)               r = longint'(sa) - longint'(sb);
        else return 1'b0;
        return r != longint'(int'(r));
    endfunction

    function automatic logic has_val3(input logic [5:0] ic, ac);
        return !(ic == IC_SPECIAL && ac inside {AC_MULT, AC_MULTU, AC_MTHI, AC_MTLO, AC_DIV, AC_DIVU});
    endfunction

    function automatic logic [31:0] ref_val3(input logic [5:0] ic, ac, input logic [31:0] a, b);
        int     sa = a;
        int     sb = b;
        longint p  = longint'(sa) * longint'(sb);
        if (ic == IC_SPECIAL) begin
            case (ac)
                AC_SLL, AC_SLLV: return b << a[4:0];
                AC_SRL, AC_SRLV: return b >> a[4:0];
                AC_SRA, AC_SRAV: return sb >>> a[4:0];
                AC_JALR:         return b;
                AC_MFHI:         return m_hi;
                AC_MFLO:         return m_lo;
                AC_ADD, AC_ADDU: return a + b;
                AC_SUB, AC_SUBU: return a - b;
                AC_AND:          return a & b;
                AC_OR:           return a | b;
                AC_XOR:          return a ^ b;
                AC_NOR:          return ~(a | b);
                AC_SLT:          return (sa < sb) ? 32'd1 : 32'd0;
                AC_SLTU:         return (a < b) ? 32'd1 : 32'd0;
                default:         return 32'd0;
            endcase
        end
        case (ic)
            IC_SLTI:     return (sa < sb) ? 32'd1 : 32'd0;
            IC_SLTIU:    return (a < b) ? 32'd1 : 32'd0;
            IC_ANDI:     return a & b;
            IC_ORI:      return a | b;
            IC_XORI:     return a ^ b;
            IC_SPECIAL2: return p[31:0];
            IC_REGIMM, IC_JAL, IC_LUI: return b;
            default:     return a + b;
        endcase
    endfunction

    task automatic ref_div(input logic sgn, input logic [31:0] a, b,
                           output logic [31:0] q, output logic [31:0] r);
        int sa = a;
        int sb = b;
        if (!sgn) begin
            if (b == 0) begin q = 32'hFFFFFFFF; r = a; end
            else begin q = a / b; r = a % b; end
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = 32'h80000000; r = 32'h0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endtask

    task automatic issue(input logic [5:0] ic, ac, input logic [31:0] v1, v2,
                         input logic [4:0] dst, input logic [5:0] exc);
        d_icode = ic; d_acode = ac; d_val1 = v1; d_val2 = v2; d_dst = dst; d_excCode = exc;
        d_pc = $urandom; d_valt = $urandom; d_inDelaySlot = 1'($urandom_range(0, 1));
        cur_pc = d_pc; cur_valt = d_valt; cur_ids = d_inDelaySlot;
        tick();
    endtask

    // Issue one instruction, compare against the model, then commit its HI/LO effect.
    task automatic exec_op(input logic [5:0] ic, ac, input logic [31:0] a, b,
                           input logic [4:0] dst, input logic [5:0] exc);
        logic        ovf;
        logic signed [63:0] ps;
        logic [63:0] pu;
        issue(ic, ac, a, b, dst, exc);
        chk("pc", e_pc, cur_pc);
        chk("ids", 32'(e_inDelaySlot), 32'(cur_ids));
        chk("busy", 32'(e_busy), 0);
        if (exc[5]) begin
            chk("exc_pass", 32'(e_excCode), 32'(exc));
            chk("exc_dst", 32'(e_dst), 0);
            chk("exc_icode", 32'(e_icode), 0);
        end else begin
            ovf = ref_ovf(ic, ac, a, b);
            chk($sformatf("exc_%h_%h", ic, ac), 32'(e_excCode), ovf ? 32'h2C : 32'h0);
            chk($sformatf("dst_%h_%h", ic, ac), 32'(e_dst), ovf ? 32'h0 : 32'(dst));
            if (has_val3(ic, ac)) chk($sformatf("val3_%h_%h", ic, ac), e_val3, ref_val3(ic, ac, a, b));
            chk("isload", 32'(e_isLoad), 32'(ic inside {IC_LB, IC_LH, IC_LW, IC_LBU, IC_LHU}));
            chk("icode", 32'(e_icode), 32'(ic));
            chk("valt", e_valt, cur_valt);
            ps = longint'(int'(a)) * longint'(int'(b));
            pu = 64'(a) * 64'(b);
            if (ic == IC_SPECIAL) begin
                case (ac)
                    AC_MULT:  {m_hi, m_lo} = ps;
                    AC_MULTU: {m_hi, m_lo} = pu;
                    AC_MTHI:  m_hi = a;
                    AC_MTLO:  m_lo = a;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic run_div(input logic [5:0] ac, input logic [31:0] a, b,
                           input int done_stall, input logic [31:0] eq, er);
        int cnt = 0;
        issue(IC_SPECIAL, ac, a, b, 5'd0, 6'd0);
        d_acode = AC_MFLO; d_dst = 5'd3;
        while (e_busy === 1'b1 && cnt < 100) begin
            cnt++;
            E_stall = 1'b1;
            tick();
        end
        chk("div_busy_cycles", cnt, 33);
        for (int i = 0; i < done_stall; i++) begin
            tick();
            chk("div_done_stall_busy", 32'(e_busy), 0);
        end
        E_stall = 1'b0;
        tick();
        chk("div_lo", e_val3, eq);
        m_lo = eq; m_hi = er;
        exec_op(IC_SPECIAL, AC_MFHI, 32'h0, 32'h0, 5'd4, 6'd0);
        chk("div_hi", e_val3, er);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pc"}, e_pc, 0);
        chk({tag, "_val3"}, e_val3, 0);
        chk({tag, "_valt"}, e_valt, 0);
        chk({tag, "_code"}, {20'b0, e_icode, e_acode}, 0);
        chk({tag, "_exc"}, 32'(e_excCode), 0);
        chk({tag, "_dst"}, 32'(e_dst), 0);
        chk({tag, "_flags"}, {29'b0, e_inDelaySlot, e_isLoad, e_busy}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic [11:0] op;
        logic [31:0] qa, qb, eq, er;
        logic [5:0]  exc;
        op_tab = '{
            {IC_SPECIAL, AC_SLL}, {IC_SPECIAL, AC_SRL}, {IC_SPECIAL, AC_SRA}, {IC_SPECIAL, AC_SLLV},
            {IC_SPECIAL, AC_SRLV}, {IC_SPECIAL, AC_SRAV}, {IC_SPECIAL, AC_JALR}, {IC_SPECIAL, AC_MFHI},
            {IC_SPECIAL, AC_MFLO}, {IC_SPECIAL, AC_MTHI}, {IC_SPECIAL, AC_MTLO}, {IC_SPECIAL, AC_MULT},
            {IC_SPECIAL, AC_MULTU}, {IC_SPECIAL, AC_ADD}, {IC_SPECIAL, AC_ADDU}, {IC_SPECIAL, AC_SUB},
            {IC_SPECIAL, AC_SUBU}, {IC_SPECIAL, AC_AND}, {IC_SPECIAL, AC_OR}, {IC_SPECIAL, AC_XOR},
            {IC_SPECIAL, AC_NOR}, {IC_SPECIAL, AC_SLT}, {IC_SPECIAL, AC_SLTU}, {IC_REGIMM, AC_BLTZAL},
            {IC_REGIMM, AC_BGEZAL}, {IC_JAL, 6'h0}, {IC_ADDI, 6'h0}, {IC_ADDIU, 6'h0},
            {IC_SLTI, 6'h0}, {IC_SLTIU, 6'h0}, {IC_ANDI, 6'h0}, {IC_ORI, 6'h0},
            {IC_XORI, 6'h0}, {IC_LUI, 6'h0}, {IC_SPECIAL2, AC_MUL}, {IC_LW, 6'h0},
            {IC_LB, 6'h0}, {IC_LHU, 6'h0}, {IC_SW, 6'h0}, {IC_SB, 6'h0}};

        resetn = 1'b0; E_stall = 1'b0; E_bubble = 1'b0; flush = 1'b0;
        d_pc = '0; d_val1 = '0; d_val2 = '0; d_valt = '0; d_icode = '0; d_acode = '0;
        d_excCode = '0; d_dst = '0; d_inDelaySlot = 1'b0;
        m_hi = '0; m_lo = '0;
        tick(); tick();
        chk_all_zero("reset");
        resetn = 1'b1;

        exec_op(IC_SPECIAL, AC_ADD, 32'h7FFFFFFF, 32'h1, 5'd9, 6'd0);
        chk("add_ovf_exc", 32'(e_excCode), 32'b101100);
        chk("add_ovf_dst", 32'(e_dst), 0);
        exec_op(IC_SPECIAL, AC_ADDU, 32'h7FFFFFFF, 32'h1, 5'd9, 6'd0);
        chk("addu_val3", e_val3, 32'h80000000);
        exec_op(IC_SPECIAL, AC_SRA, 32'd4, 32'h80000000, 5'd2, 6'd0);
        chk("sra_val3", e_val3, 32'hF8000000);
        exec_op(IC_SPECIAL, AC_SLTU, 32'h1, 32'hFFFFFFFF, 5'd2, 6'd0);
        chk("sltu_val3", e_val3, 32'h1);
        exec_op(IC_SPECIAL, AC_SLT, 32'h1, 32'hFFFFFFFF, 5'd2, 6'd0);
        chk("slt_val3", e_val3, 32'h0);
        exec_op(IC_SPECIAL, AC_MULT, 32'hFFFFFFFF, 32'h2, 5'd0, 6'd0);
        exec_op(IC_SPECIAL, AC_MFHI, 32'h0, 32'h0, 5'd5, 6'd0);
        chk("mult_hi", e_val3, 32'hFFFFFFFF);
        exec_op(IC_SPECIAL, AC_MFLO, 32'h0, 32'h0, 5'd5, 6'd0);
        chk("mult_lo", e_val3, 32'hFFFFFFFE);
        exec_op(IC_SPECIAL, AC_ADD, 32'h7FFFFFFF, 32'h1, 5'd9, 6'b101010);
        chk("exc_passthrough", 32'(e_excCode), 32'b101010);

        // Stall holds the latch, bubble empties it.
        exec_op(IC_SPECIAL, AC_ADDU, 32'd5, 32'd6, 5'd7, 6'd0);
        E_stall = 1'b1; d_val1 = 32'd100; d_dst = 5'd1;
        tick();
        chk("stall_val3", e_val3, 32'd11);
        chk("stall_dst", 32'(e_dst), 32'd7);
        E_stall = 1'b0; E_bubble = 1'b1;
        tick();
        chk("bubble_dst", 32'(e_dst), 0);
        chk("bubble_val3", e_val3, 0);
        E_bubble = 1'b0;

        for (int it = 0; it < 250; it++) begin
            op  = op_tab[$urandom_range(0, 39)];
            qa  = rnd_val();
            qb  = rnd_val();
            exc = ($urandom_range(0, 9) == 0) ? {1'b1, 5'($urandom)} : 6'd0;
            exec_op(op[11:6], op[5:0], qa, qb, 5'($urandom_range(1, 31)), exc);
        end

        run_div(AC_DIV, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFD, 32'hFFFFFFFF);
        run_div(AC_DIVU, 32'd7, 32'd0, 2, 32'hFFFFFFFF, 32'd7);
        run_div(AC_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 32'h0);
        for (int it = 0; it < 6; it++) begin
            qa = rnd_val();
            qb = rnd_val();
            if (qb == 0) qb = 32'd3;
            if (it >= 3) qb = qb >> $urandom_range(0, 31);
            if (qb == 0) qb = 32'd5;
            ref_div(it[0], qa, qb, eq, er);
            run_div(it[0] ? AC_DIV : AC_DIVU, qa, qb, it % 2, eq, er);
        end

        // Flush while the divider is running: abort, HI/LO untouched.
        issue(IC_SPECIAL, AC_DIV, 32'd1000, 32'd7, 5'd0, 6'd0);
        E_stall = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("flush_pre_busy", 32'(e_busy), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0; E_stall = 1'b0;
        chk("flush_busy", 32'(e_busy), 0);
        chk("flush_dst", 32'(e_dst), 0);
        exec_op(IC_SPECIAL, AC_MFHI, 32'h0, 32'h0, 5'd6, 6'd0);
        chk("flush_hi_kept", e_val3, m_hi);
        exec_op(IC_SPECIAL, AC_MFLO, 32'h0, 32'h0, 5'd6, 6'd0);
        chk("flush_lo_kept", e_val3, m_lo);

        // Reset in the middle of a divide.
        exec_op(IC_SPECIAL, AC_MTHI, 32'hDEADBEEF, 32'h0, 5'd0, 6'd0);
        issue(IC_SPECIAL, AC_DIV, 32'd99, 32'd4, 5'd0, 6'd0);
        E_stall = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        resetn = 1'b0;
        tick();
        chk_all_zero("reset_mid_div");
        resetn = 1'b1; E_stall = 1'b0;
        m_hi = '0; m_lo = '0;
        exec_op(IC_SPECIAL, AC_MFHI, 32'h0, 32'h0, 5'd8, 6'd0);
        chk("reset_hi", e_val3, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute (E) stage of the 5-stage MIPS pipeline. It sits directly downstream of the decode stage and latches decode's operands, destination and exception code. It computes the ALU, shift, compare, multiply and address results and drives the E forwarding path (`e_dst`/`e_val3`) back to decode. It owns the HI/LO registers and an iterative 32-step divider that stalls the pipeline while busy.

## Interface
- No parameters. Widths are fixed by the shared package.
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `E_stall` in 1: hold the E latch; from hazard control.
- `E_bubble` in 1: load a NOP into the E latch.
- `flush` in 1: exception commit; kills the E latch and aborts the divider.
- `d_pc` in 32: PC of the decode instruction.
- `d_val1` in 32: operand 1, already forwarded.
- `d_val2` in 32: operand 2, already forwarded.
- `d_valt` in 32: store data.
- `d_icode` in 6: instruction opcode class.
- `d_acode` in 6: function/sub-opcode.
- `d_excCode` in 6: bit5 = exception valid; bits 4:0 = cause code.
- `d_dst` in 5: destination register.
- `d_inDelaySlot` in 1: instruction is in a branch delay slot.
- `e_pc` out 32: latched PC.
- `e_val3` out 32: result (or memory address for loads/stores).
- `e_valt` out 32: latched store data.
- `e_icode` out 6: latched opcode class.
- `e_acode` out 6: latched sub-opcode.
- `e_excCode` out 6: exception code after E.
- `e_dst` out 5: destination; 0 means no write.
- `e_inDelaySlot` out 1: latched delay-slot flag.
- `e_isLoad` out 1: E holds LW/LB/LBU/LH/LHU; used for load-use stall.
- `e_busy` out 1: divider needs more cycles; control must stall E and all upstream stages.

## Operation
- **Latch priority** (posedge): `~resetn` > `flush` > `E_stall` (hold) > `E_bubble` > capture.
  - Reset, flush and bubble load NOP: all fields 0, `e_excCode`=0.
  - If `d_excCode[5]` is set, capture the code, PC and delay-slot flag. Zero icode/acode/dst.
- **Exception priority:**
  - An incoming `e_excCode[5]` passes through unchanged.
  - Otherwise ADD, ADDI and SUB with signed overflow set `e_excCode`=6'b101100 and force `e_dst`=0.
- **ALU ops:**
  - ADD, ADDU, ADDI, ADDIU and address ops (loads/stores): `val1+val2`, mod 2^32.
  - SUB, SUBU: `val1-val2`.
  - AND, OR, XOR, NOR, ANDI, ORI, XORI: bitwise on `val1`, `val2`.
  - LUI: `val2`, already shifted by decode.
- **Compare:** SLT/SLTI are signed, SLTU/SLTIU are unsigned. Result is {31'b0, lt}.
- **Shifts:** the shifted value is `val2`; the amount is `val1[4:0]`.
  - Decode places `sa` in `val1` for SLL/SRL/SRA, so one shifter covers the variable forms too.
  - SRA is arithmetic.
- **Link:** JAL, JALR, BGEZAL and BLTZAL produce `e_val3=val2`; decode supplies the link address.
- **Multiply:**
  - MULT/MULTU: 64-bit product, single cycle; {HI,LO} is written when E advances.
  - MUL (SPE2): `e_val3` = low 32 bits; HI/LO unchanged.
- **HI/LO moves:** MTHI/MTLO write HI/LO from `val1`. MFHI/MFLO return HI/LO.
- **HI/LO write suppression:** no HI/LO write when `e_excCode[5]` is set or `flush` is high.
- **Divider FSM:** states IDLE, RUN, DONE; 5-bit counter.
  - IDLE with DIV/DIVU in E: `e_busy`=1. Load the operand magnitudes (signed for DIV) and go to RUN.
  - RUN: one restoring step per cycle for 32 cycles; `e_busy`=1. After step 31, go to DONE.
  - DONE: `e_busy`=0. Stay in DONE while `E_stall` is high.
  - When E advances out of DONE, write LO = quotient and HI = remainder, then return to IDLE.
- **Divide sign rules:** quotient sign = sign(a)^sign(b); remainder takes sign(a).
  - 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
- **Divide by zero:** DIVU gives LO=0xFFFFFFFF, HI=dividend. DIV by zero has an unspecified value but must still have normal latency.
- **Divider abort:** `flush` or reset in any state returns the FSM to IDLE with HI/LO unchanged.
- **Back-to-back DIV:** the next DIV restarts from IDLE.

## Timing
- **ALU/MUL latency:** results are combinational from the latch and valid in the first E cycle (one cycle after capture). `e_busy`=0 throughout.
- **DIV latency:**
  - Cycle 0: IDLE, `e_busy`=1.
  - Cycles 1–32: RUN.
  - Cycle 33: DONE, `e_busy`=0.
  - HI/LO are updated at the end of cycle 33.
  - Total: 34 E cycles, assuming no external stall.
- **Forwarding:** `e_val3` from MFHI/MFLO reflects HI/LO writes committed by earlier instructions.
- **Reset values:** every output is 0; HI=LO=0; FSM IDLE; `e_busy`=0.
- **Stall-only:** `E_stall` without `e_busy` freezes the latch and the FSM (except RUN, which keeps stepping).

## Structure
- Constants for icode/acode, the exception codes (101100, 101010) and the `i1`…`i32` typedefs belong in the shared header package.
- The divider is the natural sub-module, `div_iter`:
  - inputs: start, signed, a, b, abort;
  - outputs: busy, done, q, r;
  - contains the FSM and counter.
- All other E logic stays in `execute_stage`.

## Test plan
- ADD 0x7FFFFFFF + 1 → `e_excCode`=6'b101100, `e_dst`=0; ADDU of the same operands → `e_val3`=0x80000000, no exception.
- SRA `val2`=0x80000000, `val1`=4 → 0xF8000000; SLTU 1 vs 0xFFFFFFFF → 1; SLT of the same operands → 0.
- MULT 0xFFFFFFFF × 2 (signed) → HI=0xFFFFFFFF, LO=0xFFFFFFFE; next-instruction MFHI → 0xFFFFFFFF.
- DIV −7 / 2 → `e_busy` high exactly 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 → LO=0xFFFFFFFF, HI=7.
- DIV in RUN at cycle 10, `flush` pulse → FSM IDLE next cycle, `e_busy`=0, HI/LO unchanged.
- Captured `d_excCode`=6'b101010 with ADD overflow operands → `e_excCode`=6'b101010 (passthrough wins); `resetn` low mid-DIV → all outputs 0 next cycle.
